// File: rtl/inport_req_pkg.sv
// rtl/inport_req_pkg.sv - shared constants, types and helpers for the router input-port request controller
//
// Port index constants, vector widths, flit type codes, head-field layout,
// FSM state encodings, and the XY-route / multicast-port helpers.
package inport_req_pkg;

  // Vector msb indices: port_o is [PORTW:0], per-output vectors are [PORT:0],
  // multab_o is [DSTATUS:0].
  localparam int PORTW   = 2;
  localparam int PORT    = 4;
  localparam int DSTATUS = 1;

  // Asserted level of the active-low reset.
  localparam logic ENABLE_ = 1'b0;

  // Output port indices.
  localparam logic [PORTW:0] PORT_N = 3'd0;
  localparam logic [PORTW:0] PORT_E = 3'd1;
  localparam logic [PORTW:0] PORT_S = 3'd2;
  localparam logic [PORTW:0] PORT_W = 3'd3;
  localparam logic [PORTW:0] PORT_L = 3'd4;

  // Multicast mask occupies the low bits of a multicast head.
  localparam int MASK_W = PORT + 1;

  // Flit type field, top two bits of the flit.
  typedef enum logic [1:0] {
    FT_SINGLE = 2'b00,
    FT_HEAD   = 2'b01,
    FT_BODY   = 2'b10,
    FT_TAIL   = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_XFER = 2'b10
  } state_e;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [PORTW:0] route_xy(input logic [15:0] dst_x,
                                              input logic [15:0] dst_y,
                                              input logic [15:0] my_x,
                                              input logic [15:0] my_y);
    logic [PORTW:0] p;
    if (dst_x > my_x)      p = PORT_E;
    else if (dst_x < my_x) p = PORT_W;
    else if (dst_y > my_y) p = PORT_S;
    else if (dst_y < my_y) p = PORT_N;
    else                   p = PORT_L;
    return p;
  endfunction

  // Index of the lowest set bit; 0 for an empty mask.
  function automatic logic [PORTW:0] lowest_port(input logic [PORT:0] mask);
    logic [PORTW:0] p;
    p = '0;
    for (int i = PORT; i >= 0; i--) begin
      if (mask[i]) p = i[PORTW:0];
    end
    return p;
  endfunction

  function automatic logic is_one_hot(input logic [PORT:0] mask);
    return (mask != '0) && ((mask & (mask - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/inport_fifo.sv
// rtl/inport_fifo.sv - flit storage FIFO for one router input port
//
// Ports: clk, rst_n (async active-low), push/wdata, pop, rdata (head, no
// bypass), full, empty. Push at full and pop at empty are ignored.
module inport_fifo
  import inport_req_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DATAW-1:0] wdata,
  input  logic             pop,
  output logic [DATAW-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == ENABLE_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/inport_req.sv
// rtl/inport_req.sv - router input-port request controller with XY routing and sequential multicast
//
// Ports: clk, rst_ (async active-low); in_flit/in_valid/in_ready from the
// upstream link; req_o/port_o/multab_o to the per-output arbiters and grt_i
// back; dn_ready per output; out_flit/out_valid to the crossbar; err_o pulses
// when a malformed flit is dropped.
module inport_req
  import inport_req_pkg::*;
#(
  parameter int PORTID = 0,
  parameter int DATAW  = 32,
  parameter int DEPTH  = 4,
  parameter int XW     = 4,
  parameter int MYX    = 0,
  parameter int MYY    = 0
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [DATAW-1:0]   in_flit,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               req_o,
  output logic [PORTW:0]     port_o,
  output logic [DSTATUS:0]   multab_o,
  input  logic [PORT:0]      grt_i,
  input  logic [PORT:0]      dn_ready,
  output logic [DATAW-1:0]   out_flit,
  output logic               out_valid,
  output logic               err_o
);

  state_e          state_q, state_d;
  logic [PORTW:0]  port_q, port_d;
  logic            mc_q, mc_d;
  logic [PORT:0]   mask_q, mask_d;
  logic            req_q, req_d;

  logic            full, empty, push, pop;
  logic [DATAW-1:0] head;
  flit_type_e      head_type;
  logic            head_mc;
  logic [PORT:0]   head_mask;
  logic [XW-1:0]   dst_x, dst_y;
  logic [PORTW:0]  uni_port;
  logic [PORT:0]   mask_rem;
  logic            head_is_start, head_is_end;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  inport_fifo #(
    .DATAW (DATAW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_),
    .push  (push),
    .wdata (in_flit),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign head_type     = flit_type_e'(head[DATAW-1:DATAW-2]);
  assign head_mc       = head[DATAW-3];
  assign head_mask     = head[MASK_W-1:0];
  assign dst_x         = head[2*XW-1:XW];
  assign dst_y         = head[XW-1:0];
  assign uni_port      = route_xy(16'(dst_x), 16'(dst_y), 16'(MYX), 16'(MYY));
  assign head_is_start = (head_type == FT_HEAD) || (head_type == FT_SINGLE);
  assign head_is_end   = (head_type == FT_TAIL) || (head_type == FT_SINGLE);
  assign out_flit      = head;

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    mc_d      = mc_q;
    mask_d    = mask_q;
    req_d     = req_q;
    pop       = 1'b0;
    err_o     = 1'b0;
    out_valid = 1'b0;
    mask_rem  = mask_q & ~(5'b00001 << port_q);

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          // Multicast is only legal on a single flit with a non-empty mask;
          // anything else that cannot start a packet is dropped.
          if (!head_is_start ||
              (head_mc && ((head_type != FT_SINGLE) || (head_mask == '0)))) begin
            pop   = 1'b1;
            err_o = 1'b1;
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            mc_d    = head_mc;
            if (head_mc) begin
              port_d = lowest_port(head_mask);
              mask_d = head_mask;
            end else begin
              port_d = uni_port;
              mask_d = '0;
            end
          end
        end
      end

      ST_REQ: begin
        // req_q is low for one cycle after a multicast hop; a grant is only
        // honoured while the request is actually visible to the arbiter.
        req_d = 1'b1;
        if (req_q && grt_i[port_q]) state_d = ST_XFER;
      end

      ST_XFER: begin
        out_valid = !empty;
        if (out_valid && dn_ready[port_q]) begin
          if (!mc_q) begin
            pop = 1'b1;
            if (head_is_end) begin
              state_d = ST_IDLE;
              req_d   = 1'b0;
            end
          end else begin
            // The same flit is replayed to each mask port; it leaves the
            // FIFO only after the last one.
            mask_d = mask_rem;
            req_d  = 1'b0;
            if (mask_rem != '0) begin
              state_d = ST_REQ;
              port_d  = lowest_port(mask_rem);
            end else begin
              pop     = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign req_o    = req_q;
  assign port_o   = req_q ? port_q : '0;
  assign multab_o = req_q ? {mc_q, is_one_hot(mask_q)} : '0;

  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == ENABLE_) begin
      state_q <= ST_IDLE;
      port_q  <= '0;
      mc_q    <= 1'b0;
      mask_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      mc_q    <= mc_d;
      mask_q  <= mask_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: tb/tb_inport_req.sv
// tb/tb_inport_req.sv - directed self-checking bench for inport_req
module tb_inport_req;

  logic        clk;
  logic        rst_;
  logic [31:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic        req_o;
  logic [2:0]  port_o;
  logic [1:0]  multab_o;
  logic [4:0]  grt_i;
  logic [4:0]  dn_ready;
  logic [31:0] out_flit;
  logic        out_valid;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  inport_req #(
    .PORTID (0),
    .DATAW  (32),
    .DEPTH  (4),
    .XW     (4),
    .MYX    (1),
    .MYY    (1)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req_o     (req_o),
    .port_o    (port_o),
    .multab_o  (multab_o),
    .grt_i     (grt_i),
    .dn_ready  (dn_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_uni(input logic [1:0] ft, input logic [3:0] dx,
                                         input logic [3:0] dy, input logic [7:0] pay);
    return {ft, 1'b0, 13'b0, pay, dx, dy};
  endfunction

  function automatic logic [31:0] mk_mc(input logic [7:0] pay, input logic [4:0] mask);
    return {2'b00, 1'b1, 13'b0, pay, 3'b0, mask};
  endfunction

  function automatic logic [31:0] mk_bt(input logic [1:0] ft, input logic [7:0] pay);
    return {ft, 14'b0, pay, 8'b0};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ = 1'b0; in_valid = 1'b0; in_flit = '0; grt_i = '0; dn_ready = 5'h1f;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", req_o); end
    checks++; if (port_o !== 3'd0) begin errors++; $display("FAIL rst_port got=%0h exp=0", port_o); end
    checks++; if (multab_o !== 2'b00) begin errors++; $display("FAIL rst_multab got=%0h exp=0", multab_o); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%0h exp=0", err_o); end
    cyc(); rst_ = 1'b1;
    @(negedge clk);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL rst_rel_req got=%0h exp=0", req_o); end
  endtask

  task automatic test_unicast();
    logic [31:0] h, b, t;
    h = mk_uni(2'b01, 4'd3, 4'd1, 8'h11);
    b = mk_bt(2'b10, 8'h12);
    t = mk_bt(2'b11, 8'h13);
    cyc(); in_valid = 1'b1; in_flit = h; @(negedge clk);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL uni_c1_req got=%0h exp=0", req_o); end
    cyc(); in_flit = b; @(negedge clk);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL uni_c2_req got=%0h exp=0", req_o); end
    cyc(); in_flit = t; @(negedge clk);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL uni_c3_req got=%0h exp=1", req_o); end
    checks++; if (port_o !== 3'd1) begin errors++; $display("FAIL uni_c3_port got=%0h exp=1", port_o); end
    checks++; if (multab_o !== 2'b00) begin errors++; $display("FAIL uni_c3_multab got=%0h exp=0", multab_o); end
    cyc(); in_valid = 1'b0; @(negedge clk);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL uni_c4_req got=%0h exp=1", req_o); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL uni_c4_ov got=%0h exp=0", out_valid); end
    cyc(); grt_i = 5'b00010; @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL uni_c5_ov got=%0h exp=0", out_valid); end
    cyc(); grt_i = 5'b00000; @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL uni_c6_ov got=%0h exp=1", out_valid); end
    checks++; if (out_flit !== h) begin errors++; $display("FAIL uni_c6_flit got=%0h exp=%0h", out_flit, h); end
    cyc(); @(negedge clk);
    checks++; if (out_flit !== b) begin errors++; $display("FAIL uni_c7_flit got=%0h exp=%0h", out_flit, b); end
    cyc(); @(negedge clk);
    checks++; if (out_flit !== t) begin errors++; $display("FAIL uni_c8_flit got=%0h exp=%0h", out_flit, t); end
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL uni_c8_req got=%0h exp=1", req_o); end
    cyc(); @(negedge clk);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL uni_c9_req got=%0h exp=0", req_o); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL uni_c9_ov got=%0h exp=0", out_valid); end
  endtask

  task automatic test_single_local();
    logic [31:0] s;
    s = mk_uni(2'b00, 4'd1, 4'd1, 8'h21);
    cyc(); in_valid = 1'b1; in_flit = s; @(negedge clk);
    cyc(); in_valid = 1'b0; grt_i = 5'b10000; @(negedge clk);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL sgl_c2_req got=%0h exp=0", req_o); end
    cyc(); @(negedge clk);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL sgl_c3_req got=%0h exp=1", req_o); end
    checks++; if (port_o !== 3'd4) begin errors++; $display("FAIL sgl_c3_port got=%0h exp=4", port_o); end
    checks++; if (multab_o !== 2'b00) begin errors++; $display("FAIL sgl_c3_multab got=%0h exp=0", multab_o); end
    cyc(); @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sgl_c4_ov got=%0h exp=1", out_valid); end
    checks++; if (out_flit !== s) begin errors++; $display("FAIL sgl_c4_flit got=%0h exp=%0h", out_flit, s); end
    cyc(); @(negedge clk);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL sgl_c5_req got=%0h exp=0", req_o); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sgl_c5_ov got=%0h exp=0", out_valid); end
    grt_i = 5'b00000;
  endtask

  task automatic test_multicast();
    logic [31:0] m;
    m = mk_mc(8'h31, 5'b10110);
    cyc(); in_valid = 1'b1; in_flit = m; @(negedge clk);
    cyc(); in_valid = 1'b0; @(negedge clk);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL mc_c2_req got=%0h exp=0", req_o); end
    cyc(); grt_i = 5'b00010; @(negedge clk);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL mc_c3_req got=%0h exp=1", req_o); end
    checks++; if (port_o !== 3'd1) begin errors++; $display("FAIL mc_c3_port got=%0h exp=1", port_o); end
    checks++; if (multab_o !== 2'b10) begin errors++; $display("FAIL mc_c3_multab got=%0h exp=2", multab_o); end
    cyc(); grt_i = 5'b00000; @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mc_c4_ov got=%0h exp=1", out_valid); end
    checks++; if (out_flit !== m) begin errors++; $display("FAIL mc_c4_flit got=%0h exp=%0h", out_flit, m); end
    cyc(); @(negedge clk);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL mc_c5_req_drop got=%0h exp=0", req_o); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mc_c5_ov got=%0h exp=0", out_valid); end
    cyc(); grt_i = 5'b00100; @(negedge clk);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL mc_c6_req got=%0h exp=1", req_o); end
    checks++; if (port_o !== 3'd2) begin errors++; $display("FAIL mc_c6_port got=%0h exp=2", port_o); end
    checks++; if (multab_o !== 2'b10) begin errors++; $display("FAIL mc_c6_multab got=%0h exp=2", multab_o); end
    cyc(); grt_i = 5'b00000; @(negedge clk);
    checks++; if (out_flit !== m) begin errors++; $display("FAIL mc_c7_flit got=%0h exp=%0h", out_flit, m); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mc_c7_ov got=%0h exp=1", out_valid); end
    cyc(); @(negedge clk);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL mc_c8_req_drop got=%0h exp=0", req_o); end
    cyc(); grt_i = 5'b10000; @(negedge clk);
    checks++; if (port_o !== 3'd4) begin errors++; $display("FAIL mc_c9_port got=%0h exp=4", port_o); end
    checks++; if (multab_o !== 2'b11) begin errors++; $display("FAIL mc_c9_multab got=%0h exp=3", multab_o); end
    cyc(); grt_i = 5'b00000; @(negedge clk);
    checks++; if (out_flit !== m) begin errors++; $display("FAIL mc_c10_flit got=%0h exp=%0h", out_flit, m); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mc_c10_ov got=%0h exp=1", out_valid); end
    cyc(); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mc_c11_ov got=%0h exp=0", out_valid); end
    cyc(); @(negedge clk);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL mc_c12_popped_req got=%0h exp=0", req_o); end
  endtask

  task automatic test_backpressure_full();
    logic [31:0] h, b1, b2, t, x;
    h  = mk_uni(2'b01, 4'd2, 4'd0, 8'h41);
    b1 = mk_bt(2'b10, 8'h42);
    b2 = mk_bt(2'b10, 8'h43);
    t  = mk_bt(2'b11, 8'h44);
    x  = mk_uni(2'b00, 4'd1, 4'd0, 8'h45);
    cyc(); in_valid = 1'b1; in_flit = h; @(negedge clk);
    cyc(); in_flit = b1; @(negedge clk);
    cyc(); in_flit = b2; @(negedge clk);
    checks++; if (port_o !== 3'd1) begin errors++; $display("FAIL bp_c3_port got=%0h exp=1", port_o); end
    cyc(); in_flit = t; grt_i = 5'b00010; @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_c4_in_ready got=%0h exp=1", in_ready); end
    cyc(); in_flit = x; grt_i = 5'b00000; dn_ready = 5'b11101;
    for (int c = 5; c <= 7; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_c%0d_full got=%0h exp=0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_c%0d_ov got=%0h exp=1", c, out_valid); end
      checks++; if (out_flit !== h) begin errors++; $display("FAIL bp_c%0d_flit got=%0h exp=%0h", c, out_flit, h); end
      if (c < 7) cyc();
    end
    cyc(); dn_ready = 5'h1f; @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_c8_full got=%0h exp=0", in_ready); end
    checks++; if (out_flit !== h) begin errors++; $display("FAIL bp_c8_flit got=%0h exp=%0h", out_flit, h); end
    cyc(); @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_c9_in_ready got=%0h exp=1", in_ready); end
    checks++; if (out_flit !== b1) begin errors++; $display("FAIL bp_c9_flit got=%0h exp=%0h", out_flit, b1); end
    cyc(); in_valid = 1'b0; @(negedge clk);
    checks++; if (out_flit !== b2) begin errors++; $display("FAIL bp_c10_flit got=%0h exp=%0h", out_flit, b2); end
    cyc(); @(negedge clk);
    checks++; if (out_flit !== t) begin errors++; $display("FAIL bp_c11_flit got=%0h exp=%0h", out_flit, t); end
    cyc(); @(negedge clk);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL bp_c12_req got=%0h exp=0", req_o); end
    cyc(); grt_i = 5'b00001; @(negedge clk);
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL bp_c13_req got=%0h exp=1", req_o); end
    checks++; if (port_o !== 3'd0) begin errors++; $display("FAIL bp_c13_port got=%0h exp=0", port_o); end
    cyc(); grt_i = 5'b00000; @(negedge clk);
    checks++; if (out_flit !== x) begin errors++; $display("FAIL bp_c14_flit got=%0h exp=%0h", out_flit, x); end
    cyc(); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_c15_ov got=%0h exp=0", out_valid); end
  endtask

  task automatic test_malformed();
    cyc(); in_valid = 1'b1; in_flit = mk_bt(2'b10, 8'h51); @(negedge clk);
    cyc(); in_valid = 1'b0; @(negedge clk);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL bad_body_err got=%0h exp=1", err_o); end
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL bad_body_req got=%0h exp=0", req_o); end
    cyc(); @(negedge clk);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL bad_body_err_end got=%0h exp=0", err_o); end
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL bad_body_req2 got=%0h exp=0", req_o); end
    cyc(); in_valid = 1'b1; in_flit = mk_mc(8'h52, 5'b00000); @(negedge clk);
    cyc(); in_valid = 1'b0; @(negedge clk);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL bad_mask_err got=%0h exp=1", err_o); end
    cyc(); @(negedge clk);
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL bad_mask_err_end got=%0h exp=0", err_o); end
    cyc(); @(negedge clk);
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL bad_mask_req got=%0h exp=0", req_o); end
  endtask

  task automatic test_reset_mid_xfer();
    cyc(); in_valid = 1'b1; in_flit = mk_uni(2'b01, 4'd3, 4'd1, 8'h61); @(negedge clk);
    cyc(); in_flit = mk_bt(2'b10, 8'h62); @(negedge clk);
    cyc(); in_valid = 1'b0; grt_i = 5'b00010; @(negedge clk);
    cyc(); grt_i = 5'b00000; dn_ready = 5'b11101; @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rx_pre_ov got=%0h exp=1", out_valid); end
    #1 rst_ = 1'b0;
    #1;
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL rx_async_req got=%0h exp=0", req_o); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rx_async_ov got=%0h exp=0", out_valid); end
    cyc(); rst_ = 1'b1; dn_ready = 5'h1f; @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rx_rel_in_ready got=%0h exp=1", in_ready); end
    for (int c = 0; c < 3; c++) begin
      cyc(); @(negedge clk);
      checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL rx_empty_req%0d got=%0h exp=0", c, req_o); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rx_empty_ov%0d got=%0h exp=0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_single_local();
    test_multicast();
    test_backpressure_full();
    test_malformed();
    test_reset_mid_xfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
